mole_game_ctrl: RTL and testbench
=================================

MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

Interface
REQ-001 Parameter MOLE_TIMEOUT, default 8: ticks a mole stays up before counting as a miss; legal range 1..255.
REQ-002 Parameter FEEDBACK_LEN, default 4: ticks guess_correct/guess_wrong are held; legal range 1..255.
REQ-003 Parameter LFSR_SEED, default 8'hA5: non-zero LFSR reset value.
REQ-004 master_clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (rst=0 resets).
REQ-006 tick  in  1  one-cycle game-time enable; all timers advance only on master_clk edges with tick=1.
REQ-007 start  in  1  one-cycle pulse; starts or restarts a game from IDLE or OVER.
REQ-008 btn_valid  in  1  one-cycle pulse; a debounced hole button was pressed.
REQ-009 btn_pos  in  3  hole index of the press; sampled only when btn_valid=1.
REQ-010 mole_position  out  3  current hole index; feeds vga_display mole_position.
REQ-011 mole_visible  out  1  high while a mole is up (SHOW and FEEDBACK).
REQ-012 guess_correct  out  1  hit feedback level for vga_display.
REQ-013 guess_wrong  out  1  miss/wrong feedback level for vga_display.
REQ-014 score  out  8  hits in current game.
REQ-015 lives  out  2  remaining lives.
REQ-016 game_over  out  1  high in OVER.

Function
REQ-017 FSM states: IDLE, SHOW, FEEDBACK, OVER; all outputs registered.
REQ-018 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances every master_clk cycle in every state, never zero.
REQ-019 New mole pick: cand = lfsr[2:0]; if cand equals current mole_position, position becomes (cand+1) mod 8 (no consecutive repeat); otherwise position becomes cand.
REQ-020 IDLE: mole_visible=0, both guess outputs 0; start -> score=0, lives=3, pick mole, timer=MOLE_TIMEOUT, go SHOW next cycle.
REQ-021 SHOW: btn_valid with btn_pos==mole_position -> hit; btn_valid with btn_pos!=mole_position -> wrong.
REQ-022 SHOW timer decrements on tick; tick while timer==1 -> miss (treated as wrong).
REQ-023 Button and timeout in the same cycle: button outcome wins, timeout discarded.
REQ-024 Hit: score+1, saturating at 255; guess_correct=1 from the next cycle; enter FEEDBACK with fb_timer=FEEDBACK_LEN.
REQ-025 Wrong/miss: lives-1; guess_wrong=1 from the next cycle; enter FEEDBACK.
REQ-026 Latency: btn_valid in cycle N -> guess output, score and lives updated in cycle N+1.
REQ-027 FEEDBACK: mole_position held; btn_valid ignored; fb_timer decrements on tick.
REQ-028 Tick with fb_timer==1: clear both guess outputs.
REQ-029 On that FEEDBACK exit: lives==0 -> OVER; else pick a new mole, timer=MOLE_TIMEOUT, go SHOW.
REQ-030 guess_correct and guess_wrong never both 1; both 0 outside FEEDBACK.
REQ-031 OVER: game_over=1, mole_visible=0, score frozen; start -> same actions as REQ-020.
REQ-032 start in SHOW or FEEDBACK is ignored.

Reset
REQ-033 rst=0 asynchronously forces IDLE, mole_position=0, mole_visible=0, guess_correct=0, guess_wrong=0, score=0, lives=0, game_over=0, lfsr=LFSR_SEED, timers=0.
REQ-034 Reset asserted mid-SHOW or mid-FEEDBACK aborts the game with no further output change until a start after release.

Verification (MOLE_TIMEOUT=4, FEEDBACK_LEN=2)
REQ-035 Start, then btn_valid with btn_pos=mole_position -> next cycle guess_correct=1, score=1; after 2 ticks guess_correct=0, new mole_position != old, state SHOW.
REQ-036 Start, then 4 ticks with no press -> guess_wrong=1, lives=2; after 2 ticks back in SHOW.
REQ-037 btn_valid with correct btn_pos in the same cycle as the 4th tick -> guess_correct=1, lives stays 3.
REQ-038 Three consecutive misses -> lives=0, game_over=1 after final feedback; start -> score=0, lives=3, game_over=0.
REQ-039 Press during FEEDBACK, and start during SHOW -> no change to score, lives or state.
REQ-040 Drive rst=0 mid-FEEDBACK with guess_wrong=1 -> all outputs 0 immediately, without waiting for a master_clk edge.

Source files
------------

// File: rtl/mole_game_ctrl.sv
// -----------------------------------------------------------------------------
// mole_game_ctrl
// Whack-a-mole game controller. An LFSR picks which hole the mole appears in.
// A press on the right hole scores a hit. A press on the wrong hole, or a
// timeout, costs a life. Each outcome is shown as a feedback level for a fixed
// number of game ticks. The game ends when no lives remain.
//
// Ports
//   master_clk     in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   tick           in   one-cycle game-time enable for all timers
//   start          in   pulse; starts/restarts a game from IDLE or OVER
//   btn_valid      in   pulse; debounced hole button press
//   btn_pos[2:0]   in   hole index of the press
//   mole_position  out  current mole hole index
//   mole_visible   out  mole is up (SHOW and FEEDBACK)
//   guess_correct  out  hit feedback level
//   guess_wrong    out  wrong/miss feedback level
//   score[7:0]     out  hits in the current game (saturating)
//   lives[1:0]     out  remaining lives
//   game_over      out  game has ended
// -----------------------------------------------------------------------------
module mole_game_ctrl #(
  parameter int unsigned MOLE_TIMEOUT = 8,
  parameter int unsigned FEEDBACK_LEN = 4,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [2:0] btn_pos,
  output logic [2:0] mole_position,
  output logic       mole_visible,
  output logic       guess_correct,
  output logic       guess_wrong,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int unsigned PosW   = 3;
  localparam int unsigned CntW   = 8;
  localparam int unsigned LivesW = 2;
  localparam int unsigned LfsrW  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW     = 2'd1,
    FEEDBACK = 2'd2,
    OVER     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LfsrW-1:0]    lfsr_q, lfsr_d;
  logic [CntW-1:0]     timer_q, timer_d;
  logic [CntW-1:0]     fb_q, fb_d;
  logic [PosW-1:0]     pos_q, pos_d;
  logic                vis_q, vis_d;
  logic                gc_q, gc_d;
  logic                gw_q, gw_d;
  logic [CntW-1:0]     score_q, score_d;
  logic [LivesW-1:0]   lives_q, lives_d;
  logic                go_q, go_d;

  // Event decode shared by the next-state and output logic
  logic            start_c, hit_c, wrong_c, miss_c, fb_done_c;
  logic [PosW-1:0] new_pos_c;

  always_comb begin
    start_c   = ((state_q == IDLE) || (state_q == OVER)) && start;
    hit_c     = (state_q == SHOW) && btn_valid && (btn_pos == pos_q);
    wrong_c   = (state_q == SHOW) && btn_valid && (btn_pos != pos_q);
    // A button in the same cycle takes priority over the timeout
    miss_c    = (state_q == SHOW) && !btn_valid && tick && (timer_q == CntW'(1));
    fb_done_c = (state_q == FEEDBACK) && tick && (fb_q == CntW'(1));
    // Never show the mole in the same hole twice in a row
    new_pos_c = (lfsr_q[PosW-1:0] == pos_q) ? PosW'(pos_q + PosW'(1))
                                            : lfsr_q[PosW-1:0];
  end

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; free-running, never reaches zero from a
  // non-zero seed
  assign lfsr_d = {lfsr_q[LfsrW-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // State register
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: if (start_c)                   state_d = SHOW;
      SHOW:       if (hit_c || wrong_c || miss_c) state_d = FEEDBACK;
      FEEDBACK:   if (fb_done_c)                 state_d = (lives_q == '0) ? OVER : SHOW;
      default:                                   state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    timer_d = timer_q;
    fb_d    = fb_q;
    pos_d   = pos_q;
    vis_d   = vis_q;
    gc_d    = gc_q;
    gw_d    = gw_q;
    score_d = score_q;
    lives_d = lives_q;
    go_d    = go_q;
    case (state_q)
      IDLE, OVER: begin
        if (start_c) begin
          score_d = '0;
          lives_d = LivesW'(3);
          pos_d   = new_pos_c;
          timer_d = CntW'(MOLE_TIMEOUT);
          vis_d   = 1'b1;
          go_d    = 1'b0;
          gc_d    = 1'b0;
          gw_d    = 1'b0;
        end
      end
      SHOW: begin
        if (hit_c) begin
          score_d = (score_q == '1) ? score_q : CntW'(score_q + CntW'(1));
          gc_d    = 1'b1;
          gw_d    = 1'b0;
          fb_d    = CntW'(FEEDBACK_LEN);
        end else if (wrong_c || miss_c) begin
          lives_d = LivesW'(lives_q - LivesW'(1));
          gw_d    = 1'b1;
          gc_d    = 1'b0;
          fb_d    = CntW'(FEEDBACK_LEN);
        end else if (tick) begin
          timer_d = CntW'(timer_q - CntW'(1));
        end
      end
      FEEDBACK: begin
        if (fb_done_c) begin
          gc_d = 1'b0;
          gw_d = 1'b0;
          if (lives_q == '0) begin
            vis_d = 1'b0;
            go_d  = 1'b1;
          end else begin
            pos_d   = new_pos_c;
            timer_d = CntW'(MOLE_TIMEOUT);
          end
        end else if (tick) begin
          fb_d = CntW'(fb_q - CntW'(1));
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      lfsr_q  <= LFSR_SEED;
      timer_q <= '0;
      fb_q    <= '0;
      pos_q   <= '0;
      vis_q   <= 1'b0;
      gc_q    <= 1'b0;
      gw_q    <= 1'b0;
      score_q <= '0;
      lives_q <= '0;
      go_q    <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      timer_q <= timer_d;
      fb_q    <= fb_d;
      pos_q   <= pos_d;
      vis_q   <= vis_d;
      gc_q    <= gc_d;
      gw_q    <= gw_d;
      score_q <= score_d;
      lives_q <= lives_d;
      go_q    <= go_d;
    end
  end

  assign mole_position = pos_q;
  assign mole_visible  = vis_q;
  assign guess_correct = gc_q;
  assign guess_wrong   = gw_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign game_over     = go_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mole_game_ctrl
// Self-checking bench for mole_game_ctrl (MOLE_TIMEOUT=4, FEEDBACK_LEN=2).
// A behavioural game model computes the expected outputs for every driven
// cycle and pushes them to a scoreboard queue. Each test task pops the entries
// and compares them against the DUT outputs sampled 1 ns after the clock edge.
// -----------------------------------------------------------------------------
module tb_mole_game_ctrl;

  localparam int unsigned MT   = 4;
  localparam int unsigned FB   = 2;
  localparam logic [7:0]  SEED = 8'hA5;

  localparam int S_IDLE = 0;
  localparam int S_SHOW = 1;
  localparam int S_FB   = 2;
  localparam int S_OVER = 3;

  typedef struct packed {
    logic [2:0] pos;
    logic       vis;
    logic       gc;
    logic       gw;
    logic [7:0] score;
    logic [1:0] lives;
    logic       go;
  } out_t;

  logic       clk, rst, tick, start, btn_valid;
  logic [2:0] btn_pos;
  logic [2:0] mole_position;
  logic       mole_visible, guess_correct, guess_wrong, game_over;
  logic [7:0] score;
  logic [1:0] lives;

  int n_cmp = 0;
  int n_err = 0;
  out_t sb[$];

  // Reference game model
  int         m_st;
  logic [7:0] m_lfsr, m_score, m_tmr, m_fb;
  logic [2:0] m_pos;
  logic [1:0] m_lives;
  logic       m_vis, m_gc, m_gw, m_go;

  mole_game_ctrl #(
    .MOLE_TIMEOUT(MT),
    .FEEDBACK_LEN(FB),
    .LFSR_SEED   (SEED)
  ) dut (
    .master_clk   (clk),
    .rst          (rst),
    .tick         (tick),
    .start        (start),
    .btn_valid    (btn_valid),
    .btn_pos      (btn_pos),
    .mole_position(mole_position),
    .mole_visible (mole_visible),
    .guess_correct(guess_correct),
    .guess_wrong  (guess_wrong),
    .score        (score),
    .lives        (lives),
    .game_over    (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic out_t obs();
    return {mole_position, mole_visible, guess_correct, guess_wrong, score, lives, game_over};
  endfunction

  function automatic out_t model_out();
    return {m_pos, m_vis, m_gc, m_gw, m_score, m_lives, m_go};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_lfsr = SEED; m_score = 0; m_tmr = 0; m_fb = 0;
    m_pos = 0; m_lives = 0; m_vis = 0; m_gc = 0; m_gw = 0; m_go = 0;
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs
  task automatic drive(input logic st, input logic bv, input logic [2:0] bp, input logic tk);
    logic [2:0] cand, pick;
    start = st; btn_valid = bv; btn_pos = bp; tick = tk;
    cand = m_lfsr[2:0];
    pick = (cand == m_pos) ? 3'(cand + 3'd1) : cand;
    case (m_st)
      S_IDLE, S_OVER: if (st) begin
        m_score = 0; m_lives = 3; m_pos = pick; m_tmr = 8'(MT);
        m_vis = 1; m_go = 0; m_st = S_SHOW;
      end
      S_SHOW: begin
        if (bv) begin
          if (bp == m_pos) begin
            if (m_score != 8'hFF) m_score = m_score + 8'd1;
            m_gc = 1;
          end else begin
            m_lives = m_lives - 2'd1; m_gw = 1;
          end
          m_fb = 8'(FB); m_st = S_FB;
        end else if (tk) begin
          if (m_tmr == 8'd1) begin
            m_lives = m_lives - 2'd1; m_gw = 1; m_fb = 8'(FB); m_st = S_FB;
          end else m_tmr = m_tmr - 8'd1;
        end
      end
      S_FB: if (tk) begin
        if (m_fb == 8'd1) begin
          m_gc = 0; m_gw = 0;
          if (m_lives == 2'd0) begin
            m_st = S_OVER; m_vis = 0; m_go = 1;
          end else begin
            m_pos = pick; m_tmr = 8'(MT); m_st = S_SHOW;
          end
        end else m_fb = m_fb - 8'd1;
      end
      default: ;
    endcase
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    start = 0; btn_valid = 0; btn_pos = 0; tick = 0;
  endtask

  task automatic test_reset();
    out_t o;
    rst = 0; start = 0; btn_valid = 0; btn_pos = 0; tick = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    o = obs();
    n_cmp++;
    if (o !== '0) begin n_err++; $display("FAIL reset_state: got %h want 0", o); end
    rst = 1;
  endtask

  task automatic test_idle();
    out_t o, e;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 3'(i), 1);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL idle_hold[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_hit();
    out_t o, e;
    logic [2:0] old_pos;
    drive(1, 0, 0, 0);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL start_game: got %h want %h", o, e); end
    old_pos = m_pos;
    drive(0, 1, m_pos, 0);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL hit_press: got %h want %h", o, e); end
    n_cmp++;
    if (guess_correct !== 1'b1 || score !== 8'd1) begin
      n_err++; $display("FAIL hit_latency: gc=%b score=%0d want gc=1 score=1", guess_correct, score);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL hit_feedback[%0d]: got %h want %h", i, o, e); end
    end
    n_cmp++;
    if (mole_position === old_pos || guess_correct !== 1'b0 || mole_visible !== 1'b1) begin
      n_err++; $display("FAIL hit_new_mole: pos=%0d old=%0d gc=%b vis=%b", mole_position, old_pos, guess_correct, mole_visible);
    end
  endtask

  task automatic test_race();
    out_t o, e;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL race_tick[%0d]: got %h want %h", i, o, e); end
    end
    drive(0, 1, m_pos, 1);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL race_press: got %h want %h", o, e); end
    n_cmp++;
    if (guess_correct !== 1'b1 || guess_wrong !== 1'b0 || lives !== 2'd3) begin
      n_err++; $display("FAIL race_outcome: gc=%b gw=%b lives=%0d want 1 0 3", guess_correct, guess_wrong, lives);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL race_feedback[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_miss();
    out_t o, e;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL miss_cycle[%0d]: got %h want %h", i, o, e); end
      if (i == 3) begin
        n_cmp++;
        if (guess_wrong !== 1'b1 || lives !== 2'd2) begin
          n_err++; $display("FAIL miss_outcome: gw=%b lives=%0d want 1 2", guess_wrong, lives);
        end
      end
    end
  endtask

  task automatic test_ignore();
    out_t o, e;
    logic [2:0] bad;
    drive(1, 0, 0, 0);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL start_in_show: got %h want %h", o, e); end
    bad = m_pos ^ 3'd5;
    drive(0, 1, bad, 0);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL wrong_press: got %h want %h", o, e); end
    drive(0, 1, m_pos, 0);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL press_in_fb: got %h want %h", o, e); end
    drive(1, 0, 0, 1);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL start_in_fb: got %h want %h", o, e); end
    n_cmp++;
    if (score !== 8'd2 || lives !== 2'd1 || guess_wrong !== 1'b1) begin
      n_err++; $display("FAIL ignore_state: score=%0d lives=%0d gw=%b want 2 1 1", score, lives, guess_wrong);
    end
    drive(0, 0, 0, 1);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL ignore_exit: got %h want %h", o, e); end
  endtask

  task automatic test_over();
    out_t o, e;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL last_miss[%0d]: got %h want %h", i, o, e); end
    end
    drive(0, 1, 3'd0, 1);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL over_frozen: got %h want %h", o, e); end
    n_cmp++;
    if (game_over !== 1'b1 || lives !== 2'd0 || mole_visible !== 1'b0 || score !== 8'd2) begin
      n_err++; $display("FAIL over_state: go=%b lives=%0d vis=%b score=%0d", game_over, lives, mole_visible, score);
    end
    drive(1, 0, 0, 0);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL restart: got %h want %h", o, e); end
    n_cmp++;
    if (score !== 8'd0 || lives !== 2'd3 || game_over !== 1'b0) begin
      n_err++; $display("FAIL restart_vals: score=%0d lives=%0d go=%b want 0 3 0", score, lives, game_over);
    end
    // Three consecutive misses end the new game
    for (int i = 0; i < 18; i++) begin
      drive(0, 0, 0, 1);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL triple_miss[%0d]: got %h want %h", i, o, e); end
    end
    n_cmp++;
    if (game_over !== 1'b1 || lives !== 2'd0) begin
      n_err++; $display("FAIL triple_over: go=%b lives=%0d want 1 0", game_over, lives);
    end
  endtask

  task automatic test_back_to_back();
    out_t o, e;
    drive(1, 0, 0, 0);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL b2b_start: got %h want %h", o, e); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, m_pos, 0);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL b2b_hit[%0d]: got %h want %h", i, o, e); end
      for (int j = 0; j < 2; j++) begin
        drive(0, 0, 0, 1);
        e = sb.pop_front(); o = obs(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL b2b_fb[%0d.%0d]: got %h want %h", i, j, o, e); end
      end
    end
  endtask

  task automatic test_async_reset();
    out_t o, e;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
      e = sb.pop_front(); o = obs(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL pre_reset[%0d]: got %h want %h", i, o, e); end
    end
    n_cmp++;
    if (guess_wrong !== 1'b1) begin n_err++; $display("FAIL pre_reset_gw: got %b want 1", guess_wrong); end
    #2 rst = 0;
    #1;
    o = obs(); n_cmp++;
    if (o !== '0) begin n_err++; $display("FAIL async_reset: got %h want 0", o); end
    model_reset();
    @(posedge clk);
    #1;
    o = obs(); n_cmp++;
    if (o !== '0) begin n_err++; $display("FAIL reset_hold: got %h want 0", o); end
    rst = 1;
    drive(0, 0, 0, 1);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL post_reset_idle: got %h want %h", o, e); end
    drive(1, 0, 0, 0);
    e = sb.pop_front(); o = obs(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL post_reset_start: got %h want %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_hit();
    test_race();
    test_miss();
    test_ignore();
    test_over();
    test_back_to_back();
    test_async_reset();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
